// File: rtl/sdram_init_monitor_if.sv
// SDRAM command/address bus together with the init monitor's status outputs.
// The master modport drives the bus; the slave modport is the monitor side.
interface sdram_init_monitor_if #(
    parameter int ASIZE = 12
);
    logic [3:0]       Command;
    logic [ASIZE-1:0] Saddr;
    logic             Init_ok;
    logic             Init_err;
    logic [2:0]       Err_code;
    logic [2:0]       Cas_lat;
    logic [2:0]       Burst_len;
    logic [3:0]       Ref_seen;

    modport master (
        output Command, Saddr,
        input  Init_ok, Init_err, Err_code, Cas_lat, Burst_len, Ref_seen
    );

    modport slave (
        input  Command, Saddr,
        output Init_ok, Init_err, Err_code, Cas_lat, Burst_len, Ref_seen
    );
endinterface

// File: rtl/sdram_init_monitor.sv
// Checks the SDRAM power-up command stream: order, spacing and mode-register value.
// Optional mode-word check enabled by defining SDRAM_MON_MR_CHECK_EN.
module sdram_init_monitor #(
    parameter int               ASIZE     = 12,
    parameter int               T_PWR     = 20000,
    parameter int               T_RP      = 2,
    parameter int               T_RFC     = 7,
    parameter int               T_MRD     = 2,
    parameter int               N_REF     = 2,
    parameter logic [ASIZE-1:0] MR_EXPECT = 'h032
) (
    input logic                 Clk,
    input logic                 Rst_n,
    sdram_init_monitor_if.slave bus
);

    typedef enum logic [2:0] {
        S_PWR, S_PRE, S_REF, S_LMR, S_WAIT_MRD, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [1:0] {C_NONE, C_PRE, C_REF, C_LMR} prev_t;

    localparam logic [14:0] T_PWR_C = 15'(T_PWR);
    localparam logic [15:0] T_RP_C  = 16'(T_RP);
    localparam logic [15:0] T_RFC_C = 16'(T_RFC);
    localparam logic [15:0] T_MRD_C = 16'(T_MRD);
    localparam logic [3:0]  N_REF_C = 4'(N_REF);

    state_t      state_q, state_d;
    prev_t       prev_q, prev_d;
    logic [14:0] pwr_cnt_q, pwr_cnt_d;
    logic [15:0] gap_q, gap_d;
    logic        init_ok_q, init_ok_d;
    logic        init_err_q, init_err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [2:0]  cas_lat_q, cas_lat_d;
    logic [2:0]  burst_len_q, burst_len_d;
    logic [3:0]  ref_seen_q, ref_seen_d;

    logic       is_idle, is_pre, is_ref, is_lmr;
    logic       space_err;
    logic [2:0] space_code;
    logic       fault;
    logic [2:0] fault_code;
    logic [3:0] ref_inc;
    logic       mr_ok;

    assign is_idle = bus.Command[3] || (bus.Command == 4'b0111);
    assign is_pre  = (bus.Command == 4'b0010);
    assign is_ref  = (bus.Command == 4'b0001);
    assign is_lmr  = (bus.Command == 4'b0000);
    assign ref_inc = (ref_seen_q == 4'hF) ? 4'hF : ref_seen_q + 4'd1;

`ifdef SDRAM_MON_MR_CHECK_EN
    assign mr_ok = (bus.Saddr == MR_EXPECT);
`else
    logic mr_unused;
    assign mr_ok     = 1'b1;
    assign mr_unused = ^{bus.Saddr, MR_EXPECT};
`endif

    // Minimum gap owed to the previous non-idle command
    always_comb begin
        space_err  = 1'b0;
        space_code = '0;
        case (prev_q)
            C_PRE: if (gap_q < T_RP_C)  begin space_err = 1'b1; space_code = 3'd2; end
            C_REF: if (gap_q < T_RFC_C) begin space_err = 1'b1; space_code = 3'd3; end
            C_LMR: if (gap_q < T_MRD_C) begin space_err = 1'b1; space_code = 3'd4; end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        pwr_cnt_d   = pwr_cnt_q;
        gap_d       = gap_q;
        init_ok_d   = init_ok_q;
        init_err_d  = init_err_q;
        err_code_d  = err_code_q;
        cas_lat_d   = cas_lat_q;
        burst_len_d = burst_len_q;
        ref_seen_d  = ref_seen_q;
        fault       = 1'b0;
        fault_code  = '0;

        if (!is_idle)            gap_d = 16'd1;
        else if (gap_q != '1)    gap_d = gap_q + 16'd1;

        if (!is_idle && state_q != S_DONE && state_q != S_ERROR) begin
            if (is_pre)      prev_d = C_PRE;
            else if (is_ref) prev_d = C_REF;
            else if (is_lmr) prev_d = C_LMR;
            else             prev_d = C_NONE;
        end

        case (state_q)
            // Once power-up time has elapsed, PWR accepts the PRECHARGE exactly like PRE
            S_PWR, S_PRE: begin
                if (state_q == S_PWR && is_idle && pwr_cnt_q != '1)
                    pwr_cnt_d = pwr_cnt_q + 15'd1;
                if (!is_idle) begin
                    if (space_err) begin
                        fault = 1'b1; fault_code = space_code;
                    end else if (state_q == S_PWR && pwr_cnt_q < T_PWR_C) begin
                        fault = 1'b1; fault_code = 3'd1;
                    end else if (!is_pre) begin
                        fault = 1'b1; fault_code = 3'd5;
                    end else if (!bus.Saddr[10]) begin
                        fault = 1'b1; fault_code = 3'd6;
                    end else begin
                        state_d = S_REF;
                    end
                end
            end
            S_REF: begin
                if (!is_idle) begin
                    if (space_err) begin
                        fault = 1'b1; fault_code = space_code;
                    end else if (is_ref) begin
                        ref_seen_d = ref_inc;
                        if (ref_inc == N_REF_C) state_d = S_LMR;
                    end else begin
                        fault = 1'b1; fault_code = 3'd5;
                    end
                end
            end
            S_LMR: begin
                if (!is_idle) begin
                    if (space_err) begin
                        fault = 1'b1; fault_code = space_code;
                    end else if (is_lmr && !mr_ok) begin
                        fault = 1'b1; fault_code = 3'd7;
                    end else if (is_lmr) begin
                        cas_lat_d   = bus.Saddr[6:4];
                        burst_len_d = bus.Saddr[2:0];
                        state_d     = S_WAIT_MRD;
                    end else begin
                        fault = 1'b1; fault_code = 3'd5;
                    end
                end
            end
            S_WAIT_MRD: begin
                if (gap_q >= T_MRD_C) begin
                    state_d   = S_DONE;
                    init_ok_d = 1'b1;
                end else if (!is_idle) begin
                    fault = 1'b1; fault_code = 3'd4;
                end
            end
            default: ;
        endcase

        if (fault) begin
            state_d    = S_ERROR;
            init_err_d = 1'b1;
            err_code_d = fault_code;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_PWR;
            prev_q      <= C_NONE;
            pwr_cnt_q   <= '0;
            gap_q       <= '1;
            init_ok_q   <= 1'b0;
            init_err_q  <= 1'b0;
            err_code_q  <= '0;
            cas_lat_q   <= '0;
            burst_len_q <= '0;
            ref_seen_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            pwr_cnt_q   <= pwr_cnt_d;
            gap_q       <= gap_d;
            init_ok_q   <= init_ok_d;
            init_err_q  <= init_err_d;
            err_code_q  <= err_code_d;
            cas_lat_q   <= cas_lat_d;
            burst_len_q <= burst_len_d;
            ref_seen_q  <= ref_seen_d;
        end
    end

    assign bus.Init_ok   = init_ok_q;
    assign bus.Init_err  = init_err_q;
    assign bus.Err_code  = err_code_q;
    assign bus.Cas_lat   = cas_lat_q;
    assign bus.Burst_len = burst_len_q;
    assign bus.Ref_seen  = ref_seen_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed bench for sdram_init_monitor with T_PWR shortened to 100 cycles.
module tb_sdram_init_monitor;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;
    localparam logic [3:0] ACT  = 4'b0011;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    sdram_init_monitor_if #(.ASIZE(12)) bus ();

    sdram_init_monitor #(
        .ASIZE(12), .T_PWR(100), .T_RP(2), .T_RFC(7), .T_MRD(2),
        .N_REF(2), .MR_EXPECT(12'h032)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic ok, input logic err,
                                input logic [2:0] code);
        check({tag, "_ok"},   16'(bus.Init_ok),  16'(ok));
        check({tag, "_err"},  16'(bus.Init_err), 16'(err));
        check({tag, "_code"}, 16'(bus.Err_code), 16'(code));
    endtask

    task automatic check_mode(input string tag, input logic [2:0] cas, input logic [2:0] bl,
                              input logic [3:0] refs);
        check({tag, "_cas"}, 16'(bus.Cas_lat),   16'(cas));
        check({tag, "_bl"},  16'(bus.Burst_len), 16'(bl));
        check({tag, "_ref"}, 16'(bus.Ref_seen),  16'(refs));
    endtask

    task automatic step(input logic [3:0] c, input logic [11:0] a);
        bus.Command = c;
        bus.Saddr   = a;
        @(posedge Clk);
        #1;
    endtask

    task automatic nops(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(NOP, 12'h000);
    endtask

    task automatic do_reset();
        Rst_n       = 1'b0;
        bus.Command = NOP;
        bus.Saddr   = 12'h000;
        #1;
        check_status("rst", 1'b0, 1'b0, 3'd0);
        check_mode("rst", 3'd0, 3'd0, 4'd0);
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic legal_prefix();
        nops(100);
        step(PRE, 12'h400);
        nops(2);
        step(AREF, 12'h000);
        nops(7);
        step(AREF, 12'h000);
        nops(7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Command = NOP;
        bus.Saddr   = 12'h000;
        #2;

        // Legal sequence
        do_reset();
        nops(100);
        step(PRE, 12'h400);
        check_status("s1_pre", 1'b0, 1'b0, 3'd0);
        nops(2);
        step(AREF, 12'h000);
        check_mode("s1_ref1", 3'd0, 3'd0, 4'd1);
        nops(7);
        step(AREF, 12'h000);
        check_mode("s1_ref2", 3'd0, 3'd0, 4'd2);
        nops(7);
        step(LMR, 12'h032);
        check_status("s1_lmr", 1'b0, 1'b0, 3'd0);
        check_mode("s1_lmr", 3'd3, 3'd2, 4'd2);
        step(NOP, 12'h000);
        check_status("s1_k1", 1'b0, 1'b0, 3'd0);
        step(NOP, 12'h000);
        check_status("s1_k2", 1'b1, 1'b0, 3'd0);
        step(AREF, 12'h000);
        check_status("s1_frozen", 1'b1, 1'b0, 3'd0);
        check_mode("s1_frozen", 3'd3, 3'd2, 4'd2);

        // Early PRECHARGE after 50 NOPs; error code must stay sticky
        do_reset();
        nops(50);
        step(PRE, 12'h400);
        check_status("s2_early", 1'b0, 1'b1, 3'd1);
        step(AREF, 12'h000);
        step(LMR, 12'h032);
        nops(3);
        check_status("s2_sticky", 1'b0, 1'b1, 3'd1);
        check_mode("s2_sticky", 3'd0, 3'd0, 4'd0);

        // One NOP short of the power-up time
        do_reset();
        nops(99);
        step(PRE, 12'h400);
        check_status("pwr_99", 1'b0, 1'b1, 3'd1);

        // Second AUTO REFRESH too soon
        do_reset();
        nops(100);
        step(PRE, 12'h400);
        nops(2);
        step(AREF, 12'h000);
        nops(3);
        step(AREF, 12'h000);
        check_status("s3_trfc", 1'b0, 1'b1, 3'd3);
        check_mode("s3_trfc", 3'd0, 3'd0, 4'd1);

        // PRECHARGE without A10
        do_reset();
        nops(100);
        step(PRE, 12'h000);
        check_status("s3_a10", 1'b0, 1'b1, 3'd6);

        // Spacing violation wins over the out-of-order LOAD MODE
        do_reset();
        nops(100);
        step(PRE, 12'h400);
        step(LMR, 12'h032);
        check_status("trp_prio", 1'b0, 1'b1, 3'd2);

        // ACTIVE in the refresh phase
        do_reset();
        nops(100);
        step(PRE, 12'h400);
        nops(2);
        step(AREF, 12'h000);
        nops(7);
        step(ACT, 12'h000);
        check_status("s4_act", 1'b0, 1'b1, 3'd5);

        // LOAD MODE after one refresh, spacing exactly T_RFC
        do_reset();
        nops(100);
        step(PRE, 12'h400);
        nops(2);
        step(AREF, 12'h000);
        nops(6);
        step(LMR, 12'h032);
        check_status("s4_lmr1", 1'b0, 1'b1, 3'd5);
        check_mode("s4_lmr1", 3'd0, 3'd0, 4'd1);

        // Command inside the LOAD MODE settling window
        do_reset();
        legal_prefix();
        step(LMR, 12'h032);
        step(PRE, 12'h400);
        check_status("tmrd", 1'b0, 1'b1, 3'd4);

        // Unexpected mode word
        do_reset();
        legal_prefix();
        step(LMR, 12'h022);
`ifdef SDRAM_MON_MR_CHECK_EN
        check_status("s5_mr", 1'b0, 1'b1, 3'd7);
        nops(3);
        check_status("s5_mr_hold", 1'b0, 1'b1, 3'd7);
        check_mode("s5_mr_hold", 3'd0, 3'd0, 4'd2);
`else
        nops(2);
        check_status("s5_mr", 1'b1, 1'b0, 3'd0);
        check_mode("s5_mr", 3'd2, 3'd2, 4'd2);
`endif

        // Reset pulse mid-refresh, then a full legal sequence
        do_reset();
        nops(100);
        step(PRE, 12'h400);
        nops(2);
        step(AREF, 12'h000);
        check_mode("s6_pre_rst", 3'd0, 3'd0, 4'd1);
        do_reset();
        legal_prefix();
        step(LMR, 12'h032);
        nops(2);
        check_status("s6_after", 1'b1, 1'b0, 3'd0);
        check_mode("s6_after", 3'd3, 3'd2, 4'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
